// File: rtl/seq_divider.sv
// Multi-cycle radix-2 signed divider: restoring division on 33-bit magnitudes, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase and finishes with latency 1.
module seq_divider (
    input  logic        aclk,
    input  logic        reset,
    input  logic [32:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    input  logic [32:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic [79:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state;
    logic [32:0] dvd;       // dividend magnitude; quotient bits shift in at the LSB
    logic [32:0] dsr;
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic        dvd_sign;
    logic        q_sign;
    logic        div_zero;

    logic [33:0] trial;
    logic [33:0] diff;
    logic [32:0] abs_dividend;
    logic [32:0] abs_divisor;
    logic [32:0] q_fix;
    logic [32:0] r_fix;
    logic        accept;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        trial        = {rem, dvd[32]};
        diff         = trial - {1'b0, dsr};
        abs_dividend = s_axis_dividend_tdata[32] ? (33'd0 - s_axis_dividend_tdata)
                                                 : s_axis_dividend_tdata;
        abs_divisor  = s_axis_divisor_tdata[32] ? (33'd0 - s_axis_divisor_tdata)
                                                : s_axis_divisor_tdata;
        q_fix        = q_sign ? (33'd0 - dvd) : dvd;
        if (div_zero)
            q_fix = 33'h1_FFFF_FFFF;
        // Remainder magnitude equals |dividend| on divide-by-zero, so the sign fix restores it exactly.
        r_fix        = dvd_sign ? (33'd0 - rem) : rem;
        accept       = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state              <= IDLE;
            dvd                <= '0;
            dsr                <= '0;
            rem                <= '0;
            cnt                <= '0;
            dvd_sign           <= 1'b0;
            q_sign             <= 1'b0;
            div_zero           <= 1'b0;
            m_axis_dout_tdata  <= '0;
            m_axis_dout_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd      <= abs_dividend;
                        dsr      <= abs_divisor;
                        dvd_sign <= s_axis_dividend_tdata[32];
                        q_sign   <= s_axis_dividend_tdata[32] ^ s_axis_divisor_tdata[32];
                        div_zero <= (s_axis_divisor_tdata == 33'd0);
                        cnt      <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (s_axis_divisor_tdata == 33'd0) begin
                            rem   <= abs_dividend;
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            state <= ITER;
                        end
`else
                        rem      <= '0;
                        state    <= ITER;
`endif
                    end
                end
                ITER: begin
                    if (!diff[33])
                        rem <= diff[32:0];
                    else
                        rem <= trial[32:0];
                    dvd <= {dvd[31:0], ~diff[33]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd32)
                        state <= FIX;
                end
                FIX: begin
                    m_axis_dout_tdata  <= {{7{q_fix[32]}}, q_fix, {7{r_fix[32]}}, r_fix};
                    m_axis_dout_tvalid <= 1'b1;
                    state              <= DONE;
                end
                DONE: begin
                    m_axis_dout_tvalid <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic division model.
// Expected latency for a zero divisor follows DIV_ZERO_FAST_EN when the bench is built with it.
module tb_seq_divider;

    logic        aclk = 1'b0;
    logic        reset;
    logic [32:0] s_axis_dividend_tdata;
    logic        s_axis_dividend_tvalid;
    logic [32:0] s_axis_divisor_tdata;
    logic        s_axis_divisor_tvalid;
    logic [79:0] m_axis_dout_tdata;
    logic        m_axis_dout_tvalid;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    seq_divider dut (
        .aclk                   (aclk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .m_axis_dout_tdata      (m_axis_dout_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk)
        if (m_axis_dout_tvalid) pulse_cnt++;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truncating signed division with remainder taking the dividend's sign, reduced to 33 bits.
    function automatic logic [79:0] model(input logic [32:0] a, input logic [32:0] b);
        longint      sa;
        longint      sb;
        longint      qq;
        longint      rr;
        logic [32:0] q;
        logic [32:0] r;
        sa = longint'({{31{a[32]}}, a});
        sb = longint'({{31{b[32]}}, b});
        if (b == 33'd0) begin
            q = 33'h1_FFFF_FFFF;
            r = a;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[32:0];
            r  = rr[32:0];
        end
        return {{7{q[32]}}, q, {7{r[32]}}, r};
    endfunction

    function automatic int exp_latency(input logic [32:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 33'd0) return 1;
`endif
        return 34;
    endfunction

    task automatic issue(input logic [32:0] a, input logic [32:0] b, input logic va, input logic vb);
        @(negedge aclk);
        s_axis_dividend_tdata  = a;
        s_axis_divisor_tdata   = b;
        s_axis_dividend_tvalid = va;
        s_axis_divisor_tvalid  = vb;
        @(posedge aclk);
        #1;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
    endtask

    task automatic wait_result(input int start, input int max, output int lat, output bit got);
        lat = start;
        got = 1'b0;
        while (lat < max && !got) begin
            @(posedge aclk);
            #1;
            lat++;
            if (m_axis_dout_tvalid) got = 1'b1;
        end
    endtask

    // Full operation: result must appear at the expected latency, pulse once and then hold.
    task automatic run_op(input string tag, input logic [32:0] a, input logic [32:0] b);
        int          lat;
        bit          got;
        logic [79:0] exp;
        exp = model(a, b);
        issue(a, b, 1'b1, 1'b1);
        wait_result(0, 100, lat, got);
        check({tag, "_seen"}, 80'(got), 80'd1);
        check({tag, "_lat"}, 80'(lat), 80'(exp_latency(b)));
        check({tag, "_data"}, m_axis_dout_tdata, exp);
        @(posedge aclk);
        #1;
        check({tag, "_drop"}, 80'(m_axis_dout_tvalid), 80'd0);
        @(posedge aclk);
        #1;
        check({tag, "_hold"}, m_axis_dout_tdata, exp);
    endtask

    initial begin
        int          lat;
        bit          got;
        logic [32:0] a;
        logic [32:0] b;
        logic [79:0] exp;

        reset                  = 1'b1;
        s_axis_dividend_tdata  = '0;
        s_axis_divisor_tdata   = '0;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b0;
        check("rst_tvalid", 80'(m_axis_dout_tvalid), 80'd0);
        check("rst_tdata", m_axis_dout_tdata, 80'd0);

        run_op("u100_7", 33'h0_0000_0064, 33'h0_0000_0007);
        check("u100_7_q", {48'd0, m_axis_dout_tdata[71:40]}, 80'd14);
        check("u100_7_r", {48'd0, m_axis_dout_tdata[31:0]}, 80'd2);
        run_op("s_m7_2", 33'h1_FFFF_FFF9, 33'h0_0000_0002);
        run_op("divu_max_1", 33'h0_FFFF_FFFF, 33'h0_0000_0001);
        run_op("div0_5", 33'h0_0000_0005, 33'h0_0000_0000);
        run_op("div0_neg", 33'h1_FFFF_FFF0, 33'h0_0000_0000);
        run_op("wrap", 33'h1_0000_0000, 33'h1_FFFF_FFFF);
        run_op("max_neg", 33'h0_FFFF_FFFF, 33'h1_0000_0000);

        // Only one tvalid at a time must never start an operation.
        pulse_cnt = 0;
        issue(33'd9, 33'd3, 1'b1, 1'b0);
        issue(33'd9, 33'd3, 1'b0, 1'b1);
        repeat (45) @(posedge aclk);
        #1;
        check("half_valid_pulses", 80'(pulse_cnt), 80'd0);

        // A second request while busy is ignored.
        pulse_cnt = 0;
        issue(33'd100, 33'd7, 1'b1, 1'b1);
        repeat (9) @(posedge aclk);
        issue(33'd9, 33'd3, 1'b1, 1'b1);
        wait_result(10, 100, lat, got);
        check("busy_lat", 80'(lat), 80'd34);
        check("busy_data", m_axis_dout_tdata, model(33'd100, 33'd7));
        repeat (40) @(posedge aclk);
        #1;
        check("busy_pulses", 80'(pulse_cnt), 80'd1);
        run_op("after_busy_9_3", 33'd9, 33'd3);

        // Reset in flight abandons the operation and clears the output.
        pulse_cnt = 0;
        issue(33'd100, 33'd7, 1'b1, 1'b1);
        repeat (19) @(posedge aclk);
        @(negedge aclk);
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        repeat (50) @(posedge aclk);
        #1;
        check("rst_mid_pulses", 80'(pulse_cnt), 80'd0);
        check("rst_mid_tdata", m_axis_dout_tdata, 80'd0);
        run_op("after_rst_8_2", 33'd8, 33'd2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    a = 33'($signed($urandom_range(0, 2000)) - 1000);
                    b = 33'($signed($urandom_range(0, 40)) - 20);
                end
                1: begin
                    a = {1'($urandom), 32'($urandom)};
                    b = 33'($signed($urandom_range(0, 600)) - 300);
                end
                2: begin
                    a = {1'($urandom), 32'($urandom)};
                    b = 33'd0;
                end
                default: begin
                    a = {1'($urandom), 32'($urandom)};
                    b = {1'($urandom), 32'($urandom)};
                    if ($urandom_range(0, 1) == 1) b = b >>> $urandom_range(0, 28);
                end
            endcase
            exp = model(a, b);
            issue(a, b, 1'b1, 1'b1);
            wait_result(0, 100, lat, got);
            check($sformatf("rnd%0d_lat a=%h b=%h", i, a, b), 80'(lat), 80'(exp_latency(b)));
            check($sformatf("rnd%0d_data a=%h b=%h", i, a, b), m_axis_dout_tdata, exp);
            repeat (2) @(posedge aclk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
